prog_counter_div: RTL and testbench

Parametrised successor to the fixed 4-bit divide-by-2 counter. It is a synchronous WIDTH-bit counter with programmable modulus, up/down direction, enable and parallel load. It also produces a one-cycle wrap pulse and a 50%-duty divided clock-enable output. It sits in the synchronous sequential counter library and replaces the per-bit `out0..outN` taps with a single `count` bus plus derived timing outputs.

---
 rtl/counter_pkg.sv | 16 +
 rtl/prog_counter_div_if.sv | 35 +++
 rtl/toggle_ff.sv | 29 ++
 rtl/prog_counter_div.sv | 78 +++++++
 tb/tb_prog_counter_div.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the synchronous counter library.
//   DEFAULT_WIDTH : default counter width in bits
//   dir_e         : count direction encoding used for the `up` input
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter_pkg

// File: rtl/prog_counter_div_if.sv
// ----------------------------------------------------------------------------
// prog_counter_div_if
// Control and status bundle of the programmable counter/divider.
//   en       : count enable (0 = hold)
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous parallel load strobe
//   load_val : value loaded when load = 1
//   modulus  : terminal value M, count range 0..M
//   count    : registered counter value
//   wrap     : one-cycle pulse in the cycle count shows a wrap result
//   div_out  : divided clock-enable, toggles on every wrap
// The master drives the controls; the slave (the counter) drives the status.
// ----------------------------------------------------------------------------
interface prog_counter_div_if #(
    parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             div_out;

    modport master (
        output en, up, load, load_val, modulus,
        input  count, wrap, div_out
    );

    modport slave (
        input  en, up, load, load_val, modulus,
        output count, wrap, div_out
    );
endinterface : prog_counter_div_if

// File: rtl/toggle_ff.sv
// ----------------------------------------------------------------------------
// toggle_ff
// T flip-flop with asynchronous active-high reset.
//   clk : clock, rising edge
//   rst : asynchronous reset, forces q to 0
//   t   : toggle request, q inverts on the next edge when high
//   q   : registered output
// ----------------------------------------------------------------------------
module toggle_ff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_q;

    // Invert on request, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule : toggle_ff

// File: rtl/prog_counter_div.sv
// ----------------------------------------------------------------------------
// prog_counter_div
// WIDTH-bit counter with programmable modulus, up/down direction, enable and
// parallel load, plus a registered wrap pulse and a 50%-duty divided output.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (count, wrap, div_out -> 0)
//   bus : prog_counter_div_if slave modport (controls in, status out)
// Priority per edge: rst > load > en > hold.
// ----------------------------------------------------------------------------
module prog_counter_div
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    prog_counter_div_if.slave   bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             div_q;
    dir_e             dir;

    assign dir = dir_e'(bus.up);

    // Next count and wrap. An up-count at or above M wraps to 0, so a value
    // loaded beyond M returns to range on the next enabled edge. A down-count
    // only wraps from 0, so an out-of-range value decrements into range.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (bus.en) begin
            if (dir == DIR_UP) begin
                if (count_q >= bus.modulus) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = bus.modulus;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // div_out flips on the same edge that registers the wrap pulse.
    toggle_ff u_div (
        .clk (clk),
        .rst (rst),
        .t   (wrap_d),
        .q   (div_q)
    );

    assign bus.count   = count_q;
    assign bus.wrap    = wrap_q;
    assign bus.div_out = div_q;

endmodule : prog_counter_div

// File: tb/tb_prog_counter_div.sv
// ----------------------------------------------------------------------------
// tb_prog_counter_div
// Directed bench for prog_counter_div (WIDTH = 4). Inputs change just after
// the falling edge; outputs are sampled at the falling edge.
// ----------------------------------------------------------------------------
module tb_prog_counter_div;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    prog_counter_div_if #(.WIDTH(WIDTH)) bus ();

    prog_counter_div #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic up, input logic load,
                                 input logic [WIDTH-1:0] loadVal,
                                 input logic [WIDTH-1:0] modulus);
        bus.en       = en;
        bus.up       = up;
        bus.load     = load;
        bus.load_val = loadVal;
        bus.modulus  = modulus;
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int expCount, input int expWrap,
                            input int expDiv);
        checkOutput({tag, ".count"},   32'(bus.count),   32'(expCount));
        checkOutput({tag, ".wrap"},    32'(bus.wrap),    32'(expWrap));
        checkOutput({tag, ".div_out"}, 32'(bus.div_out), 32'(expDiv));
    endtask

    int downSeq [7] = '{5, 4, 3, 2, 1, 0, 5};
    int downWrap[7] = '{1, 0, 0, 0, 0, 0, 1};
    int downDiv [7] = '{1, 1, 1, 1, 1, 1, 0};

    initial begin
        checks   = 0;
        failures = 0;

        // Reset state with the enable already asserted.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
        tick();
        tick();
        checkAll("reset_init", 0, 0, 0);
        rst = 1'b0;

        // Up counting with M = 9: 1..9,0 repeating, div_out flips every 10.
        for (int i = 1; i <= 37; i++) begin
            tick();
            checkAll($sformatf("up9_c%0d", i), i % 10, (i % 10 == 0) ? 1 : 0,
                     ((i / 10) % 2 == 1) ? 1 : 0);
        end

        // Asynchronous reset between edges, with count=7 and div_out=1.
        #2 rst = 1'b1;
        #1 checkAll("rst_async", 0, 0, 0);
        tick();
        tick();
        checkAll("rst_hold", 0, 0, 0);
        rst = 1'b0;

        // Down counting with M = 5 from 0.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkAll($sformatf("down5_c%0d", i), downSeq[i], downWrap[i], downDiv[i]);
        end

        // Out-of-range load above M, then one enabled up edge wraps to 0.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd12, 4'd9);
        tick();
        checkAll("load12", 12, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
        tick();
        checkAll("load12_wrap", 0, 1, 1);

        // M = 0: every enabled edge wraps, div_out toggles each cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkAll($sformatf("m0_c%0d", i), 0, 1, (i % 2 == 0) ? 0 : 1);
        end

        // Load 3 with en = 0, then hold for four cycles.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 4'd9);
        tick();
        checkAll("load3", 3, 0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkAll($sformatf("hold_c%0d", i), 3, 0, 1);
        end

        // Load wins over a deasserted enable, then count up with M = 15.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 4'd9);
        tick();
        checkAll("load7", 7, 0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd15);
        tick();
        checkAll("m15_8", 8, 0, 1);

        // Full-range binary count: 9..15 then wrap to 0.
        for (int i = 9; i <= 16; i++) begin
            tick();
            checkAll($sformatf("m15_c%0d", i), i % 16, (i == 16) ? 1 : 0,
                     (i == 16) ? 0 : 1);
        end

        // Direction reversal mid-count: 0 -> 15 (wrap), 14, then up 15.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
        tick();
        checkAll("rev_dn1", 15, 1, 1);
        tick();
        checkAll("rev_dn2", 14, 0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd15);
        tick();
        checkAll("rev_up", 15, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_counter_div
